hsi_m_rx_nch: RTL
=================

// Module: hsi_m_rx_nch
// PURPOSE
//  Parametrised HSI master receive path. Successor to the fixed two-line receiver.
//  - Deserialises words from one of NCH redundant data lines.
//  - Checks odd parity and the stop bit.
//  - Optionally fails over to the next line on error.
//  - Buffers words in a FWFT FIFO with a ready/ack handshake toward the host side.
// PARAMETERS
//  NCH        2   number of redundant data lines (>=2); SW = $clog2(NCH)
//  DW         8   data bits per word
//  FIFO_DEPTH 16  output FIFO depth in words (power of 2, >=2)
// PORTS
//  clk        in   1      system clock
//  rst        in   1      synchronous reset, active high
//  clk_en     in   1      bit-rate strobe; one line bit is sampled per strobe
//  sdreq_en   in   1      receiver enable; low aborts any word in progress
//  dat_src    in   SW     manual line select (used when auto_sel=0)
//  auto_sel   in   1      1 = automatic failover on error
//  dat        in   NCH    serial data lines, idle high
//  q          out  DW     FIFO head word
//  q_rdy      out  1      FIFO not empty
//  q_ack      in   1      pop head word (honoured only when q_rdy=1)
//  ch_active  out  SW     line currently being received
//  par_err    out  1      1-cycle pulse: parity error
//  frm_err    out  1      1-cycle pulse: stop bit sampled as 0
//  ovf        out  1      1-cycle pulse: word dropped because FIFO was full
// BEHAVIOUR
//  - Reset: every output is 0, the FSM is in IDLE, the FIFO is empty.
//  - dat passes through a 2-flop synchroniser on clk. Only dat[ch_active] is sampled.
//  - Frame: start bit 0, then DW data bits LSB first, then odd-parity bit, then stop bit 1.
//  - FSM advances only on clk_en ticks:
//    - IDLE -> DATA when the sampled bit = 0 (start bit).
//    - DATA -> PAR after DW bits.
//    - PAR -> STOP.
//    - STOP -> IDLE.
//  - Parity rule: XOR of the data bits and the parity bit must equal 1. Otherwise par_err.
//  - Stop rule: stop bit = 0 -> frm_err. Both errors may pulse together.
//  - An errored word is never written to the FIFO.
//  - Write latency: the stop-bit tick occurs at cycle T.
//    - Valid word: FIFO write and error pulses at T+1.
//    - q_rdy high from T+1 if the FIFO was empty.
//  - Line selection: in IDLE only, ch_active loads dat_src when auto_sel=0.
//    - Mid-word changes to dat_src or auto_sel are held off until IDLE.
//  - Auto mode: any error sets ch_active <= (ch_active==NCH-1) ? 0 : ch_active+1.
//    - Applied at T+1; the next start bit is searched on the new line.
//  - dat_src >= NCH: value is ignored and ch_active holds.
//  - sdreq_en low: FSM forced to IDLE next cycle.
//    - Partial word discarded, no error pulses.
//    - FIFO contents and ch_active retained.
//  - FIFO is FWFT: q is valid whenever q_rdy=1. q_ack with q_rdy=0 is ignored.
//  - Full FIFO with a valid word and no pop that cycle: word dropped, ovf pulses.
//  - Full FIFO with a simultaneous pop and push: both happen, no ovf.
//  - Empty FIFO with a push: no bypass; q_rdy rises the cycle after the write.
//  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is $clog2(FIFO_DEPTH)+1.
// CONFIGURATION
//  HSI_RX_ERR_CNT_EN defined:
//    - Extra output err_cnt [15:0], reset 0.
//    - Increments by 1 per errored word: par and frm together count once.
//    - Also increments on each ovf.
//    - Saturates at 16'hFFFF.
//  HSI_RX_ERR_CNT_EN undefined: port and logic are absent; behaviour otherwise identical.
// TESTING (NCH=2, DW=8, FIFO_DEPTH=4, clk_en every 4th clk)
//  1. Receive 0xA5, parity bit 1, on dat[0], dat_src=0.
//     -> q=8'hA5 and q_rdy=1 at T+1; q_ack pulse -> q_rdy=0 next cycle.
//  2. Receive 0x3C with parity bit 0, auto_sel=1.
//     -> par_err pulse, no write, ch_active 0->1; next 0x11 (parity 1) on dat[1] received.
//  3. Five valid words 0x01..0x05, no q_ack.
//     -> ovf pulses on the 5th; popping yields 0x01..0x04 in order, then q_rdy=0.
//  4. Drop sdreq_en after 3 data bits of 0xFF, restore, then send 0x5A.
//     -> only 0x5A appears; no error pulses.
//  5. Stop bit 0 on dat[1], ch_active=1, auto_sel=1.
//     -> frm_err pulse, ch_active wraps to 0.
//  6. With HSI_RX_ERR_CNT_EN: 2 parity errors + 1 word with both errors + 1 ovf -> err_cnt=4.
//     Force 16'hFFFF then one more error -> err_cnt stays 16'hFFFF.
//  Reset asserted mid-word -> all outputs 0 next cycle, FIFO empty.

Source files
------------

// File: rtl/hsi_m_rx_nch.sv
// hsi_m_rx_nch: HSI master receive path with NCH redundant serial lines.
// Deserialises start/DW data/odd-parity/stop frames from the selected line.
// Optional automatic failover to the next line on error.
// Good words go into a first-word-fall-through FIFO toward the host.
// Optional feature: define HSI_RX_ERR_CNT_EN to add the saturating err_cnt_o counter.
module hsi_m_rx_nch #(
  parameter int NCH        = 2,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int SW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clk_en_i,
  input  logic           sdreq_en_i,
  input  logic [SW-1:0]  dat_src_i,
  input  logic           auto_sel_i,
  input  logic [NCH-1:0] dat_i,
  output logic [DW-1:0]  q_o,
  output logic           q_rdy_o,
  input  logic           q_ack_i,
  output logic [SW-1:0]  ch_active_o,
  output logic           par_err_o,
  output logic           frm_err_o,
  output logic           ovf_o
`ifdef HSI_RX_ERR_CNT_EN
  ,
  output logic [15:0]    err_cnt_o
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_e;

  state_e         state_q, state_d;
  logic [NCH-1:0] sync1_q, sync2_q;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]  shreg_q, shreg_d;
  logic           par_bit_q, par_bit_d;
  logic           auto_q;
  logic [SW-1:0]  ch_q, ch_d;
  logic           par_err_q, par_err_d;
  logic           frm_err_q, frm_err_d;
  logic           ovf_q, ovf_d;
  logic [DW-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    cnt_q, cnt_d;

  logic rx_bit, src_ok, stop_tick, bad_par, bad_stop, word_err;
  logic push, pop, full, do_wr;

  // Two-flop synchroniser; resets to the idle-high line level so no false start
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= dat_i;
      sync2_q <= sync1_q;
    end
  end

  assign rx_bit = sync2_q[ch_q];
  assign src_ok = (int'(dat_src_i) < NCH);

  // Frame state register and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_bit_q <= par_bit_d;
    end
  end

  // Next-state: advance one frame bit per clk_en tick; disable aborts to IDLE
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_bit_d = par_bit_q;
    stop_tick = 1'b0;
    if (!sdreq_en_i) begin
      state_d = IDLE;
    end else if (clk_en_i) begin
      case (state_q)
        IDLE: begin
          if (!rx_bit) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          // LSB arrives first, so shift in from the top
          shreg_d   = (shreg_q >> 1) | (DW'(rx_bit) << (DW - 1));
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CW'(DW - 1)) state_d = PAR;
        end
        PAR: begin
          par_bit_d = rx_bit;
          state_d   = STOP;
        end
        STOP: begin
          stop_tick = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Word checks evaluated on the stop-bit tick
  assign bad_par  = stop_tick && !(^{shreg_q, par_bit_q});
  assign bad_stop = stop_tick && !rx_bit;
  assign word_err = bad_par || bad_stop;
  assign push     = stop_tick && !word_err;
  assign full     = (cnt_q == (AW + 1)'(FIFO_DEPTH));
  assign pop      = q_ack_i && q_rdy_o;
  // A pop in the same cycle frees the slot even when full
  assign do_wr    = push && (!full || pop);

  // Error and overflow pulse sources
  always_comb begin
    par_err_d = bad_par;
    frm_err_d = bad_stop;
    ovf_d     = push && full && !pop;
  end

  // One-cycle status pulses, visible the cycle after the stop tick
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      ovf_q     <= ovf_d;
    end
  end

  // Line select: manual reload only in IDLE; failover uses the mode latched at word start
  always_comb begin
    ch_d = ch_q;
    if (state_q == IDLE) begin
      if (!auto_sel_i && src_ok) ch_d = dat_src_i;
    end else if (auto_q && word_err) begin
      ch_d = (ch_q == SW'(NCH - 1)) ? '0 : ch_q + 1'b1;
    end
  end

  // Line select register and the auto mode captured while idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ch_q   <= '0;
      auto_q <= 1'b0;
    end else begin
      ch_q <= ch_d;
      if (state_q == IDLE) auto_q <= auto_sel_i;
    end
  end

  // FIFO occupancy next value
  always_comb begin
    cnt_d = cnt_q + (AW + 1)'(do_wr) - (AW + 1)'(pop);
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage, no reset needed since reads are masked while empty
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= shreg_q;
  end

`ifdef HSI_RX_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // One count per errored word (both errors count once) or dropped word, saturating
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((word_err || ovf_d) && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  // Error counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

  assign q_rdy_o     = (cnt_q != '0);
  // Head is forced to zero while empty so the output is defined from reset
  assign q_o         = q_rdy_o ? mem_q[rd_ptr_q] : '0;
  assign ch_active_o = ch_q;
  assign par_err_o   = par_err_q;
  assign frm_err_o   = frm_err_q;
  assign ovf_o       = ovf_q;

endmodule
